// File: rtl/salamander_sndcmd_tx.sv
// Main-CPU to sound-CPU command transmitter: byte FIFO feeding a timed
// code/interrupt handshake with a guard gap between successive codes.
module salamander_sndcmd_tx #(
    parameter int unsigned FIFO_AW     = 2,
    parameter int unsigned PULSE_TICKS = 4,
    parameter int unsigned GAP_TICKS   = 512
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_RST,
    input  logic               i_EMU_CLK3M58_PCEN,
    input  logic               i_CODE_WR,
    input  logic [7:0]         i_CODE_DIN,
    input  logic               i_FLUSH,
    output logic [7:0]         o_SNDCODE,
    output logic               o_SNDINT,
    output logic               o_BUSY,
    output logic               o_FULL,
    output logic [FIFO_AW:0]   o_LEVEL,
    output logic               o_OVERFLOW
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned CW    = 16;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [LW-1:0]        r_level;
    logic                 r_full;
    logic                 r_overflow;
    logic [CW-1:0]        r_cnt;
    logic [7:0]           r_code;
    logic                 r_int;

    logic                 w_push;
    logic                 w_pop;
    logic [LW-1:0]        w_level_nxt;

    // Flush takes priority over both FIFO ports; a full FIFO refuses writes
    // even when the transmitter pops in the same cycle.
    assign w_push = i_CODE_WR && !i_FLUSH && !r_full;
    assign w_pop  = (r_state == ST_IDLE) && (r_level != '0) && !i_FLUSH;

    always_comb begin
        w_level_nxt = r_level;
        if (i_FLUSH) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_FLUSH) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LEVEL_FULL);
            if (i_CODE_WR && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries below the level are ever read.
    always_ff @(posedge i_EMU_MCLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_CODE_DIN;
        end
    end

    // Transmit sequencer: present code, pulse the IRQ, then hold through the gap
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_code  <= 8'h00;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_code  <= r_mem[r_rptr];
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_int   <= 1'b1;
                    r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (i_EMU_CLK3M58_PCEN) begin
                        if (r_cnt == PULSE_LAST) begin
                            r_int   <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (i_EMU_CLK3M58_PCEN) begin
                        if (r_cnt == GAP_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_SNDCODE  = r_code;
    assign o_SNDINT   = r_int;
    assign o_FULL     = r_full;
    assign o_LEVEL    = r_level;
    assign o_OVERFLOW = r_overflow;
    assign o_BUSY     = (r_state != ST_IDLE) || (r_level != '0);

endmodule

// File: tb/tb_salamander_sndcmd_tx.sv
// Bench for salamander_sndcmd_tx: transaction-level reference model plus an
// edge-detecting receiver model, directed scenarios and a randomized soak.
module tb_salamander_sndcmd_tx;

    localparam int P     = 4;
    localparam int G     = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcen;
    logic       wr;
    logic [7:0] din;
    logic       flush;
    logic [7:0] o_sndcode;
    logic       o_sndint;
    logic       o_busy;
    logic       o_full;
    logic [2:0] o_level;
    logic       o_overflow;

    salamander_sndcmd_tx #(
        .FIFO_AW    (2),
        .PULSE_TICKS(P),
        .GAP_TICKS  (G)
    ) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_RST         (rst),
        .i_EMU_CLK3M58_PCEN(pcen),
        .i_CODE_WR         (wr),
        .i_CODE_DIN        (din),
        .i_FLUSH           (flush),
        .o_SNDCODE         (o_sndcode),
        .o_SNDINT          (o_sndint),
        .o_BUSY            (o_busy),
        .o_FULL            (o_full),
        .o_LEVEL           (o_level),
        .o_OVERFLOW        (o_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;
    int pcen_mode = 0;   // 0: every 6th cycle, 1: random, 2: held low

    // Reference model: queue of pending bytes, and a transaction that lasts
    // one setup cycle followed by P+G ticks, the first P of them with IRQ high.
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] rx_log[$];
    logic [7:0] m_code;
    bit         m_ovf;
    int         m_phase;   // 0 waiting for a byte, 1 setup cycle, 2 ticking
    int         m_rem;
    int         m_sent_total;
    bit         rx_s1, rx_s2, rx_s3;

    task automatic model_reset();
        mq.delete();
        sent_q.delete();
        m_code  = 8'h00;
        m_ovf   = 1'b0;
        m_phase = 0;
        m_rem   = 0;
        rx_s1 = 1'b0; rx_s2 = 1'b0; rx_s3 = 1'b0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input bit f, input bit p);
        int sz;
        bit pop, push;
        sz   = mq.size();
        pop  = (m_phase == 0) && (sz > 0) && !f;
        push = w && !f && (sz < DEPTH);
        if (f) m_ovf = 1'b0;
        else if (w && sz == DEPTH) m_ovf = 1'b1;
        case (m_phase)
            0: if (pop) begin
                m_code = mq[0];
                sent_q.push_back(mq[0]);
                m_sent_total++;
                m_phase = 1;
            end
            1: begin
                m_phase = 2;
                m_rem   = P + G;
            end
            default: if (p) begin
                m_rem--;
                if (m_rem == 0) m_phase = 0;
            end
        endcase
        if (f) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
        end
    endtask

    // One MCLK: drive, advance model, compare all outputs, run receiver model.
    task automatic cyc(input bit w, input logic [7:0] d, input bit f);
        bit e_int, e_full, e_busy;
        logic [7:0] exp_code;
        @(negedge clk);
        wr = w; din = d; flush = f;
        case (pcen_mode)
            0: pcen = (cyc_no % 6 == 0);
            1: pcen = ($urandom_range(2) == 0);
            default: pcen = 1'b0;
        endcase
        @(posedge clk);
        cyc_no++;
        if (rst) model_reset();
        else model_step(w, d, f, pcen);
        #1;
        e_int  = (m_phase == 2) && (m_rem > G);
        e_full = (mq.size() == DEPTH);
        e_busy = (m_phase != 0) || (mq.size() != 0);
        n_checks++;
        if ({o_sndcode, o_sndint, o_level, o_full, o_busy, o_overflow} !==
            {m_code, e_int, 3'(mq.size()), e_full, e_busy, m_ovf}) begin
            $display("FAIL cycle%0d outputs: got code=%h int=%b lvl=%0d full=%b busy=%b ovf=%b, want code=%h int=%b lvl=%0d full=%b busy=%b ovf=%b",
                     cyc_no, o_sndcode, o_sndint, o_level, o_full, o_busy, o_overflow,
                     m_code, e_int, mq.size(), e_full, e_busy, m_ovf);
        end else n_pass++;
        if (rst) begin
            rx_s1 = 1'b0; rx_s2 = 1'b0; rx_s3 = 1'b0;
        end else begin
            rx_s3 = rx_s2; rx_s2 = rx_s1; rx_s1 = o_sndint;
            if (rx_s2 && !rx_s3) begin
                n_checks++;
                if (sent_q.size() == 0) begin
                    $display("FAIL rx_irq: got IRQ with code %h, want no IRQ", o_sndcode);
                end else begin
                    exp_code = sent_q.pop_front();
                    if (o_sndcode !== exp_code)
                        $display("FAIL rx_code: got %h want %h", o_sndcode, exp_code);
                    else n_pass++;
                end
                rx_log.push_back(o_sndcode);
            end
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((o_busy === 1'b1 || m_phase != 0 || mq.size() != 0) && g < 20000) begin
            cyc(1'b0, 8'h00, 1'b0);
            g++;
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (g >= 20000) $display("FAIL drain_timeout: got busy after %0d cycles, want idle", g);
        else n_pass++;
    endtask

    task automatic wait_int_high();
        int g = 0;
        while (o_sndint !== 1'b1 && g < 2000) begin
            cyc(1'b0, 8'h00, 1'b0);
            g++;
        end
        n_checks++;
        if (o_sndint !== 1'b1) $display("FAIL wait_int: got int=%b, want 1", o_sndint);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; din = 8'h00; flush = 1'b0; pcen = 1'b0;
        model_reset();
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        n_checks++;
        if ({o_sndcode, o_sndint, o_busy, o_full, o_level, o_overflow} !== 15'h0)
            $display("FAIL reset_state: got code=%h int=%b busy=%b full=%b lvl=%0d ovf=%b, want all 0",
                     o_sndcode, o_sndint, o_busy, o_full, o_level, o_overflow);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_single_write();
        int ticks, g;
        pcen_mode = 0;
        rx_log.delete();
        cyc(1'b1, 8'h3A, 1'b0);
        n_checks++;
        if (o_level !== 3'd1) $display("FAIL single_t1_level: got %0d want 1", o_level);
        else n_pass++;
        cyc(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (o_sndcode !== 8'h3A || o_level !== 3'd0)
            $display("FAIL single_t2: got code=%h lvl=%0d want code=3a lvl=0", o_sndcode, o_level);
        else n_pass++;
        cyc(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (o_sndint !== 1'b1) $display("FAIL single_t3_int: got %b want 1", o_sndint);
        else n_pass++;
        ticks = 0; g = 0;
        while (o_sndint === 1'b1 && g < 2000) begin
            cyc(1'b0, 8'h00, 1'b0);
            if (pcen) ticks++;
            g++;
        end
        n_checks++;
        if (ticks != P) $display("FAIL single_pulse_ticks: got %0d want %0d", ticks, P);
        else n_pass++;
        ticks = 0; g = 0;
        while (o_busy === 1'b1 && g < 2000) begin
            cyc(1'b0, 8'h00, 1'b0);
            if (pcen) ticks++;
            g++;
        end
        n_checks++;
        if (ticks != G || o_sndcode !== 8'h3A)
            $display("FAIL single_gap: got ticks=%0d code=%h want ticks=%0d code=3a", ticks, o_sndcode, G);
        else n_pass++;
        n_checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'h3A)
            $display("FAIL single_rx: got %0d irqs want 1 with code 3a", rx_log.size());
        else n_pass++;
    endtask

    task automatic test_burst();
        rx_log.delete();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 1'b0);
        n_checks++;
        if (o_full !== 1'b1 || o_level !== 3'd4)
            $display("FAIL burst_full: got full=%b lvl=%0d want full=1 lvl=4", o_full, o_level);
        else n_pass++;
        cyc(1'b1, 8'h06, 1'b0);
        n_checks++;
        if (o_overflow !== 1'b1 || o_level !== 3'd4)
            $display("FAIL burst_ovf: got ovf=%b lvl=%0d want ovf=1 lvl=4", o_overflow, o_level);
        else n_pass++;
        drain();
        n_checks++;
        if (rx_log.size() != 5) $display("FAIL burst_count: got %0d irqs want 5", rx_log.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < rx_log.size(); i++) begin
            n_checks++;
            if (rx_log[i] !== 8'(i + 1)) $display("FAIL burst_order[%0d]: got %h want %h", i, rx_log[i], 8'(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp_seq[4];
        int g = 0;
        exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hA4;
        rx_log.delete();
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0);
        while (!(m_phase == 0 && mq.size() == 2) && g < 5000) begin
            cyc(1'b0, 8'h00, 1'b0);
            g++;
        end
        cyc(1'b1, 8'hA4, 1'b0);
        n_checks++;
        if (o_level !== 3'd2 || o_sndcode !== 8'hA2)
            $display("FAIL pushpop_level: got lvl=%0d code=%h want lvl=2 code=a2", o_level, o_sndcode);
        else n_pass++;
        drain();
        n_checks++;
        if (rx_log.size() != 4) $display("FAIL pushpop_count: got %0d irqs want 4", rx_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < rx_log.size(); i++) begin
            n_checks++;
            if (rx_log[i] !== exp_seq[i]) $display("FAIL pushpop_order[%0d]: got %h want %h", i, rx_log[i], exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        int ticks = 0;
        int g = 0;
        rx_log.delete();
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0);
        cyc(1'b1, 8'hC4, 1'b0);
        n_checks++;
        if (o_level !== 3'd3 || o_overflow !== 1'b1)
            $display("FAIL flush_pre: got lvl=%0d ovf=%b want lvl=3 ovf=1", o_level, o_overflow);
        else n_pass++;
        wait_int_high();
        while (o_sndint === 1'b1 && g < 2000) begin
            cyc(1'b0, 8'h00, (g == 3));
            if (pcen) ticks++;
            if (g == 3) begin
                n_checks++;
                if (o_level !== 3'd0 || o_overflow !== 1'b0 || o_sndint !== 1'b1)
                    $display("FAIL flush_clear: got lvl=%0d ovf=%b int=%b want lvl=0 ovf=0 int=1",
                             o_level, o_overflow, o_sndint);
                else n_pass++;
            end
            g++;
        end
        n_checks++;
        if (ticks != P) $display("FAIL flush_pulse_width: got %0d ticks want %0d", ticks, P);
        else n_pass++;
        cyc(1'b1, 8'h99, 1'b1);
        n_checks++;
        if (o_level !== 3'd0 || o_overflow !== 1'b0)
            $display("FAIL flush_with_write: got lvl=%0d ovf=%b want lvl=0 ovf=0", o_level, o_overflow);
        else n_pass++;
        drain();
        n_checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'hC1)
            $display("FAIL flush_no_more_pulses: got %0d irqs want 1 (c1)", rx_log.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        rx_log.delete();
        cyc(1'b1, 8'h5C, 1'b0);
        cyc(1'b1, 8'h5D, 1'b0);
        cyc(1'b1, 8'h5E, 1'b0);
        wait_int_high();
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (o_sndint !== 1'b0 || o_sndcode !== 8'h00 || o_level !== 3'd0)
            $display("FAIL async_reset: got int=%b code=%h lvl=%0d want int=0 code=00 lvl=0",
                     o_sndint, o_sndcode, o_level);
        else n_pass++;
        model_reset();
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rx_log.delete();
        cyc(1'b1, 8'hFF, 1'b0);
        drain();
        n_checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'hFF || o_sndcode !== 8'hFF)
            $display("FAIL after_reset_tx: got %0d irqs code=%h want 1 irq code=ff", rx_log.size(), o_sndcode);
        else n_pass++;
    endtask

    task automatic test_pcen_stall();
        int g = 0;
        rx_log.delete();
        cyc(1'b1, 8'hE1, 1'b0);
        while (!(m_phase == 2 && m_rem <= G - 2) && g < 2000) begin
            cyc(1'b0, 8'h00, 1'b0);
            g++;
        end
        pcen_mode = 2;
        for (int i = 0; i < 1000; i++) cyc((i == 500), 8'hE2, 1'b0);
        n_checks++;
        if (o_sndint !== 1'b0 || o_busy !== 1'b1 || o_sndcode !== 8'hE1 || o_level !== 3'd1)
            $display("FAIL stall_hold: got int=%b busy=%b code=%h lvl=%0d want int=0 busy=1 code=e1 lvl=1",
                     o_sndint, o_busy, o_sndcode, o_level);
        else n_pass++;
        pcen_mode = 0;
        drain();
        n_checks++;
        if (rx_log.size() != 2 || rx_log[0] !== 8'hE1 || rx_log[1] !== 8'hE2)
            $display("FAIL stall_rx: got %0d irqs want 2 (e1,e2)", rx_log.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit w, f;
        logic [7:0] d;
        rx_log.delete();
        m_sent_total = 0;
        pcen_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            w = ($urandom_range(9) == 0);
            f = ($urandom_range(399) == 0);
            d = 8'($urandom);
            cyc(w, d, f);
        end
        drain();
        n_checks++;
        if (rx_log.size() != m_sent_total || sent_q.size() != 0)
            $display("FAIL random_irq_count: got %0d irqs want %0d", rx_log.size(), m_sent_total);
        else n_pass++;
        pcen_mode = 0;
    endtask

    initial begin
        model_reset();
        m_sent_total = 0;
        test_reset();
        test_single_write();
        test_burst();
        test_push_pop();
        test_flush();
        test_reset_mid_pulse();
        test_pcen_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/salamander_sndcmd_tx.md
# salamander_sndcmd_tx

Main-board sound command transmitter: the sending end of the main-CPU → sound-CPU command link. It accepts byte writes from the main-CPU bus decoder into a small FIFO. It presents each byte on the 8-bit sound-code bus and raises a timed sound-interrupt pulse for each one. It holds the code stable through a guard gap so the sound CPU's edge-detected IRQ and later code read both land on the correct byte.

## Interface
Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth 4)
- PULSE_TICKS, 4, o_SNDINT high time in CLK3M58 positive-enable ticks; legal range 1..255
- GAP_TICKS, 512, minimum low/hold time after the pulse, in ticks, before the next code is presented; legal range 1..65535

Ports:
- i_EMU_MCLK  in  1  master clock; all logic on posedge
- i_EMU_RST  in  1  asynchronous, active-high reset
- i_EMU_CLK3M58_PCEN  in  1  tick enable for PULSE/GAP counters
- i_CODE_WR  in  1  single-cycle write strobe, already qualified by the bus decoder
- i_CODE_DIN  in  8  byte to send
- i_FLUSH  in  1  single-cycle FIFO clear and overflow clear
- o_SNDCODE  out  8  registered code to the sound board
- o_SNDINT  out  1  registered interrupt pulse to the sound board
- o_BUSY  out  1  FSM not IDLE, or FIFO not empty
- o_FULL  out  1  FIFO full
- o_LEVEL  out  FIFO_AW+1  FIFO occupancy
- o_OVERFLOW  out  1  sticky: a write was dropped

## Operation
- **FIFO:** circular, FIFO_AW-bit read and write pointers, plus an occupancy counter.
  - Push on i_CODE_WR when not full.
  - i_CODE_WR while full: byte dropped, o_OVERFLOW set.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- **i_FLUSH:** pointers and level cleared, o_OVERFLOW cleared.
  - i_FLUSH and i_CODE_WR in the same cycle: flush wins; write dropped; o_OVERFLOW stays 0.
  - Flush does not abort an in-flight transaction.
- **FSM states:** IDLE, LOAD, PULSE, GAP.
  - IDLE: if FIFO not empty, pop the head into o_SNDCODE, go to LOAD.
  - LOAD: one cycle. Clear the tick counter, set o_SNDINT, go to PULSE.
  - PULSE: on each PCEN, counter++. On the PCEN where counter == PULSE_TICKS-1: clear o_SNDINT, clear the counter, go to GAP.
  - GAP: on each PCEN, counter++. On the PCEN where counter == GAP_TICKS-1: go to IDLE. o_SNDCODE is held throughout.
- **Code register:** o_SNDCODE changes only on the IDLE→LOAD transition and keeps its value while IDLE.
- **Counter:** 16 bits; ticks are counted only in PULSE and GAP.
- **Reset values:**
  - o_SNDCODE = 8'h00, o_SNDINT = 0.
  - o_BUSY = 0, o_FULL = 0, o_LEVEL = 0, o_OVERFLOW = 0.
  - State IDLE, pointers 0, counter 0.
- **Reset mid-pulse:** o_SNDINT falls immediately (asynchronous); queued bytes are lost.

## Timing
- **Write into empty FIFO, FSM in IDLE, i_CODE_WR at cycle t:**
  - t+1: o_LEVEL = 1.
  - t+2: o_SNDCODE = new byte, o_LEVEL = 0.
  - t+3: o_SNDINT = 1.
- **Setup guarantee:** o_SNDCODE is stable at least one MCLK before o_SNDINT rises and stays stable until the next IDLE→LOAD. The receiver's multi-stage synchroniser therefore always samples a settled code.
- **Pulse width:** exactly PULSE_TICKS PCEN ticks, ±1 MCLK alignment to the first tick after entering PULSE.
- **Back-to-back bytes:** successive o_SNDINT rising edges are separated by at least (PULSE_TICKS+GAP_TICKS) ticks plus 2 MCLK.
- **Flags:** o_FULL and o_LEVEL are registered and update the cycle after the push or pop. o_BUSY is combinational from the registered state and level.
- **PCEN held low:** the FSM stalls in PULSE or GAP indefinitely; the FIFO keeps accepting writes.

## Test plan
- **Single write:** reset, then write 8'h3A with PULSE_TICKS=4, GAP_TICKS=16, PCEN every 6 MCLK.
  - o_SNDCODE = 8'h3A at t+2; o_SNDINT high at t+3 for 4 ticks.
  - o_BUSY low after 16 further ticks; o_SNDCODE still 8'h3A.
- **Burst of 5 writes in consecutive cycles (8'h01..8'h05) into depth 4:**
  - First byte is popped at t+1, so all 5 are accepted; o_FULL = 1 at t+5.
  - Sixth write 8'h06 is dropped and sets o_OVERFLOW.
  - Output sequence is 01..05, one pulse each, with each gap honoured.
- **Simultaneous push/pop:** write at the exact cycle IDLE pops the head with level 2 → level stays 2, and ordering is preserved.
- **Flush during PULSE with 3 queued bytes:**
  - Current pulse completes with full width.
  - Level becomes 0 and o_OVERFLOW is cleared.
  - No further pulses; flush+write in the same cycle leaves level 0.
- **Asynchronous reset asserted mid-PULSE:**
  - o_SNDINT = 0 and o_SNDCODE = 8'h00 within the same cycle.
  - After release, a write of 8'hFF produces a normal transaction.
- **Receiver check:** PCEN stalled during GAP for 1000 MCLK → no state change. Driving the sound board's edge-detect synchroniser model from o_SNDINT yields exactly one detected IRQ per byte, each reading the matching code.
